vfu_result_wb_arbiter: RTL and testbench

// Lane-level responder for the result-write req/gnt interface driven by the vector ALU and MFPU

---
 rtl/vfu_result_wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_vfu_result_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vfu_result_wb_arbiter.sv
// rtl/vfu_result_wb_arbiter.sv - two-source result FIFOs merged round-robin onto one VRF write port
module vfu_result_wb_arbiter #(
    parameter int  NrVInsn     = 8,
    parameter int  FifoDepth   = 2,
    parameter type vaddr_t     = logic,
    parameter type elen_simd_t = logic [63:0],
    localparam int DataWidth   = $bits(elen_simd_t),
    localparam int StrbWidth   = DataWidth / 8,
    localparam int IdWidth     = (NrVInsn > 1) ? $clog2(NrVInsn) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alu_result_req_i,
    input  logic [IdWidth-1:0]   alu_result_id_i,
    input  vaddr_t               alu_result_addr_i,
    input  logic [DataWidth-1:0] alu_result_wdata_i,
    input  logic [StrbWidth-1:0] alu_result_be_i,
    output logic                 alu_result_gnt_o,
    input  logic                 mfpu_result_req_i,
    input  logic [IdWidth-1:0]   mfpu_result_id_i,
    input  vaddr_t               mfpu_result_addr_i,
    input  logic [DataWidth-1:0] mfpu_result_wdata_i,
    input  logic [StrbWidth-1:0] mfpu_result_be_i,
    output logic                 mfpu_result_gnt_o,
    output logic                 vrf_req_o,
    output logic [IdWidth-1:0]   vrf_id_o,
    output vaddr_t               vrf_addr_o,
    output logic [DataWidth-1:0] vrf_wdata_o,
    output logic [StrbWidth-1:0] vrf_be_o,
    output logic                 vrf_src_o,
    input  logic                 vrf_gnt_i,
    output logic [NrVInsn-1:0]   wb_done_o
);

    localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntWidth = $clog2(FifoDepth + 1);

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        vaddr_t               addr;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] be;
    } entry_t;

    // Index 0 is the ALU source, index 1 the MFPU source.
    entry_t              mem_q    [2][FifoDepth];
    logic [PtrWidth-1:0] rd_ptr_q [2];
    logic [PtrWidth-1:0] wr_ptr_q [2];
    logic [CntWidth-1:0] count_q  [2];

    entry_t in_entry [2];
    logic   in_req   [2];
    logic   gnt      [2];
    logic   push     [2];
    logic   pop      [2];
    logic   nonempty [2];

    logic   live_q;
    logic   rr_q;
    logic   lock_q;
    logic   lock_src_q;
    logic   sel;
    logic   fire;
    entry_t head;
    logic [NrVInsn-1:0] done_q;

    assign in_req[0]   = alu_result_req_i;
    assign in_req[1]   = mfpu_result_req_i;
    assign in_entry[0] = '{id: alu_result_id_i, addr: alu_result_addr_i,
                           wdata: alu_result_wdata_i, be: alu_result_be_i};
    assign in_entry[1] = '{id: mfpu_result_id_i, addr: mfpu_result_addr_i,
                           wdata: mfpu_result_wdata_i, be: mfpu_result_be_i};

    // Grant depends only on the request and registered state; a full FIFO never
    // grants, even when it is popping in the same cycle.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            nonempty[s] = (count_q[s] != '0);
            gnt[s]      = in_req[s] & live_q & (count_q[s] < CntWidth'(FifoDepth));
            push[s]     = in_req[s] & gnt[s];
        end
    end

    assign alu_result_gnt_o  = gnt[0];
    assign mfpu_result_gnt_o = gnt[1];

    // Selection: a stalled write keeps its source; otherwise the only non-empty
    // FIFO wins, and a tie goes to the round-robin pointer.
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_src_q;
        end else if (nonempty[0] && nonempty[1]) begin
            sel = rr_q;
        end else if (nonempty[1]) begin
            sel = 1'b1;
        end
    end

    assign head   = mem_q[sel][rd_ptr_q[sel]];
    assign fire   = nonempty[sel] & vrf_gnt_i;
    assign pop[0] = fire & ~sel;
    assign pop[1] = fire & sel;

    // Payload is forced to zero whenever nothing is presented.
    assign vrf_req_o   = nonempty[sel];
    assign vrf_id_o    = vrf_req_o ? head.id    : '0;
    assign vrf_addr_o  = vrf_req_o ? head.addr  : '0;
    assign vrf_wdata_o = vrf_req_o ? head.wdata : '0;
    assign vrf_be_o    = vrf_req_o ? head.be    : '0;
    assign vrf_src_o   = vrf_req_o & sel;
    assign wb_done_o   = done_q;

    // FIFO storage; contents need no reset because counts gate visibility.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                mem_q[s][wr_ptr_q[s]] <= in_entry[s];
            end
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    wr_ptr_q[s] <= (wr_ptr_q[s] == PtrWidth'(FifoDepth - 1)) ? '0 : wr_ptr_q[s] + 1'b1;
                end
                if (pop[s]) begin
                    rd_ptr_q[s] <= (rd_ptr_q[s] == PtrWidth'(FifoDepth - 1)) ? '0 : rd_ptr_q[s] + 1'b1;
                end
                if (push[s] && !pop[s]) begin
                    count_q[s] <= count_q[s] + 1'b1;
                end else if (!push[s] && pop[s]) begin
                    count_q[s] <= count_q[s] - 1'b1;
                end
            end
        end
    end

    // Arbitration state: stall lock, round-robin pointer and the post-reset
    // quiet cycle that keeps the grants low right after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q     <= 1'b0;
            rr_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (fire) begin
                lock_q <= 1'b0;
                if (nonempty[0] && nonempty[1]) begin
                    rr_q <= ~sel;
                end
            end else if (vrf_req_o) begin
                lock_q     <= 1'b1;
                lock_src_q <= sel;
            end
        end
    end

    // One-hot completion pulse in the cycle after each committed write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= '0;
        end else if (fire) begin
            done_q <= NrVInsn'(1) << head.id;
        end else begin
            done_q <= '0;
        end
    end

endmodule

// File: tb/tb_vfu_result_wb_arbiter.sv
// tb/tb_vfu_result_wb_arbiter.sv - scoreboard bench for vfu_result_wb_arbiter
module tb_vfu_result_wb_arbiter;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_req = 1'b0, mfpu_req = 1'b0;
    logic [2:0]  alu_id = '0, mfpu_id = '0;
    logic [15:0] alu_addr = '0, mfpu_addr = '0;
    logic [63:0] alu_wdata = '0, mfpu_wdata = '0;
    logic [7:0]  alu_be = '0, mfpu_be = '0;
    logic        alu_gnt, mfpu_gnt;
    logic        vrf_req, vrf_src, vrf_gnt = 1'b0;
    logic [2:0]  vrf_id;
    logic [15:0] vrf_addr;
    logic [63:0] vrf_wdata;
    logic [7:0]  vrf_be;
    logic [7:0]  wb_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vfu_result_wb_arbiter #(
        .NrVInsn    (8),
        .FifoDepth  (2),
        .vaddr_t    (logic [15:0]),
        .elen_simd_t(logic [63:0])
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .alu_result_req_i   (alu_req),
        .alu_result_id_i    (alu_id),
        .alu_result_addr_i  (alu_addr),
        .alu_result_wdata_i (alu_wdata),
        .alu_result_be_i    (alu_be),
        .alu_result_gnt_o   (alu_gnt),
        .mfpu_result_req_i  (mfpu_req),
        .mfpu_result_id_i   (mfpu_id),
        .mfpu_result_addr_i (mfpu_addr),
        .mfpu_result_wdata_i(mfpu_wdata),
        .mfpu_result_be_i   (mfpu_be),
        .mfpu_result_gnt_o  (mfpu_gnt),
        .vrf_req_o          (vrf_req),
        .vrf_id_o           (vrf_id),
        .vrf_addr_o         (vrf_addr),
        .vrf_wdata_o        (vrf_wdata),
        .vrf_be_o           (vrf_be),
        .vrf_src_o          (vrf_src),
        .vrf_gnt_i          (vrf_gnt),
        .wb_done_o          (wb_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic r, input logic [2:0] id, input logic [15:0] a,
                             input logic [63:0] d, input logic [7:0] be);
        alu_req = r; alu_id = id; alu_addr = a; alu_wdata = d; alu_be = be;
    endtask

    task automatic drive_mfpu(input logic r, input logic [2:0] id, input logic [15:0] a,
                              input logic [63:0] d, input logic [7:0] be);
        mfpu_req = r; mfpu_id = id; mfpu_addr = a; mfpu_wdata = d; mfpu_be = be;
    endtask

    // Scoreboard: expected FIFO contents and arbitration state.
    ent_t       q0[$];
    ent_t       q1[$];
    logic       rr_m = 1'b0, lock_m = 1'b0, lsrc_m = 1'b0, live_m = 1'b0;
    logic [7:0] done_m = '0;

    always @(negedge clk) begin
        logic e_alu_gnt, e_mfpu_gnt, ne0, ne1, sel, e_req;
        ent_t hd;
        ent_t na, nm;
        if (!rst_n) begin
            q0.delete(); q1.delete();
            rr_m = 1'b0; lock_m = 1'b0; lsrc_m = 1'b0; live_m = 1'b0; done_m = '0;
            chk("reset_vrf_req", vrf_req, 0);
            chk("reset_wb_done", wb_done, 0);
            chk("reset_alu_gnt", alu_gnt, 0);
        end else begin
            ne0 = (q0.size() != 0);
            ne1 = (q1.size() != 0);
            e_alu_gnt  = alu_req  && live_m && (q0.size() < 2);
            e_mfpu_gnt = mfpu_req && live_m && (q1.size() < 2);
            if (lock_m)         sel = lsrc_m;
            else if (ne0 && ne1) sel = rr_m;
            else if (ne1)        sel = 1'b1;
            else                 sel = 1'b0;
            e_req = sel ? ne1 : ne0;
            chk("alu_gnt", alu_gnt, e_alu_gnt);
            chk("mfpu_gnt", mfpu_gnt, e_mfpu_gnt);
            chk("vrf_req", vrf_req, e_req);
            chk("wb_done", wb_done, done_m);
            done_m = '0;
            if (e_req) begin
                hd = sel ? q1[0] : q0[0];
                chk("vrf_src", vrf_src, sel);
                chk("vrf_id", vrf_id, hd.id);
                chk("vrf_addr", vrf_addr, hd.addr);
                chk("vrf_wdata", vrf_wdata, hd.wdata);
                chk("vrf_be", vrf_be, hd.be);
                if (vrf_gnt) begin
                    done_m = 8'(1) << hd.id;
                    if (ne0 && ne1) rr_m = ~sel;
                    if (sel) void'(q1.pop_front());
                    else     void'(q0.pop_front());
                    lock_m = 1'b0;
                end else begin
                    lock_m = 1'b1;
                    lsrc_m = sel;
                end
            end
            na = '{id: alu_id, addr: alu_addr, wdata: alu_wdata, be: alu_be};
            nm = '{id: mfpu_id, addr: mfpu_addr, wdata: mfpu_wdata, be: mfpu_be};
            if (e_alu_gnt)  q0.push_back(na);
            if (e_mfpu_gnt) q1.push_back(nm);
            live_m = 1'b1;
        end
    end

    initial begin
        // Reset, then one request in the quiet cycle right after release.
        repeat (3) step();
        rst_n = 1'b1;
        vrf_gnt = 1'b1;
        drive_alu(1, 3'd3, 16'h0010, 64'hA, 8'hFF);
        @(negedge clk); chk("t1_gnt_quiet_cycle", alu_gnt, 0);
        step();
        @(negedge clk); chk("t1_gnt_accept", alu_gnt, 1);
        step();
        drive_alu(0, 0, 0, 0, 0);
        @(negedge clk); chk("t1_vrf_req", vrf_req, 1); chk("t1_vrf_addr", vrf_addr, 16'h10);
        step();
        @(negedge clk); chk("t1_wb_done", wb_done, 8'h08);
        step();

        // Both sources streaming, VRF always ready; be=0 entries included.
        for (int i = 0; i < 8; i++) begin
            drive_alu(1, 3'(i), 16'(16'h100 + i), 64'(64'hA000 + i), 8'(i * 17));
            drive_mfpu(1, 3'(7 - i), 16'(16'h200 + i), 64'(64'hB000 + i), 8'h00);
            step();
        end
        drive_alu(0, 0, 0, 0, 0);
        drive_mfpu(0, 0, 0, 0, 0);
        repeat (6) step();

        // VRF stalled 5 cycles while ALU pushes 3: 2 accepted, third refused.
        vrf_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_alu(1, 3'(1 + i), 16'(16'h300 + i), 64'(64'hC000 + i), 8'h0F);
            @(negedge clk); chk("t3_gnt_pattern", alu_gnt, (i < 2) ? 1 : 0);
            step();
        end
        drive_alu(0, 0, 0, 0, 0);
        repeat (2) step();
        vrf_gnt = 1'b1;
        repeat (4) step();

        // MFPU locked on the port; a later ALU entry must wait for it.
        vrf_gnt = 1'b0;
        drive_mfpu(1, 3'd5, 16'h0400, 64'hD0, 8'hF0);
        step();
        drive_mfpu(0, 0, 0, 0, 0);
        drive_alu(1, 3'd6, 16'h0500, 64'hE0, 8'h3C);
        @(negedge clk); chk("t4_src_mfpu_first", vrf_src, 1);
        step();
        drive_alu(0, 0, 0, 0, 0);
        @(negedge clk); chk("t4_src_held", vrf_src, 1);
        step();
        vrf_gnt = 1'b1;
        step();
        @(negedge clk); chk("t4_src_alu_after", vrf_src, 0); chk("t4_id_alu", vrf_id, 6);
        repeat (3) step();

        // Full FIFO with a simultaneous pop and request.
        vrf_gnt = 1'b0;
        drive_alu(1, 3'd2, 16'h0600, 64'hF0, 8'h01);
        step();
        drive_alu(1, 3'd4, 16'h0601, 64'hF1, 8'h02);
        step();
        vrf_gnt = 1'b1;
        drive_alu(1, 3'd7, 16'h0602, 64'hF2, 8'h04);
        @(negedge clk); chk("t5_full_no_gnt", alu_gnt, 0);
        step();
        @(negedge clk); chk("t5_gnt_next", alu_gnt, 1);
        step();
        drive_alu(0, 0, 0, 0, 0);
        repeat (5) step();

        // Reset with two entries buffered per source.
        vrf_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_alu(1, 3'(i), 16'(16'h700 + i), 64'(64'h70 + i), 8'hFF);
            drive_mfpu(1, 3'(4 + i), 16'(16'h800 + i), 64'(64'h80 + i), 8'hFF);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("t6_req_zero", vrf_req, 0);
        chk("t6_alu_gnt_zero", alu_gnt, 0);
        chk("t6_mfpu_gnt_zero", mfpu_gnt, 0);
        chk("t6_wdata_zero", vrf_wdata, 0);
        chk("t6_done_zero", wb_done, 0);
        drive_alu(0, 0, 0, 0, 0);
        drive_mfpu(0, 0, 0, 0, 0);
        repeat (2) step();
        rst_n = 1'b1;
        vrf_gnt = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("end_alu_queue_drained", 64'(q0.size()), 0);
        chk("end_mfpu_queue_drained", 64'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
